// File: rtl/midi_voice_alloc.sv
// Polyphonic voice allocator: scans the voice bank one slot per cycle, then
// retriggers, allocates or steals the oldest voice, with sustain-pedal hold.
module midi_voice_alloc #(
  parameter int VOICES = 4,
  parameter int KEY_W  = 8,
  parameter int AGE_W  = 4,
  parameter int CNT_W  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ev_valid,
  input  logic [KEY_W-1:0]          ev_key,
  input  logic [KEY_W-1:0]          ev_vel,
  output logic                      ev_ready,
  input  logic                      sustain,
  input  logic                      all_off,
  output logic [VOICES*KEY_W-1:0]   voice_key,
  output logic [VOICES*KEY_W-1:0]   voice_vel,
  output logic [VOICES-1:0]         voice_gate,
  output logic [VOICES-1:0]         voice_start,
  output logic [CNT_W-1:0]          active_count
);

  localparam int IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VOICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [KEY_W-1:0]          ev_key_q, ev_key_d;
  logic [KEY_W-1:0]          ev_vel_q, ev_vel_d;
  logic                      match_found_q, match_found_d;
  logic [IDX_W-1:0]          match_idx_q, match_idx_d;
  logic                      free_found_q, free_found_d;
  logic [IDX_W-1:0]          free_idx_q, free_idx_d;
  logic                      old_found_q, old_found_d;
  logic [IDX_W-1:0]          old_idx_q, old_idx_d;
  logic [AGE_W-1:0]          old_age_q, old_age_d;
  logic [VOICES*KEY_W-1:0]   key_q, key_d;
  logic [VOICES*KEY_W-1:0]   vel_q, vel_d;
  logic [VOICES*AGE_W-1:0]   age_q, age_d;
  logic [VOICES-1:0]         gate_q, gate_d;
  logic [VOICES-1:0]         held_q, held_d;
  logic [VOICES-1:0]         start_q, start_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      sus_q, sus_d;
  logic                      rel_pending_q, rel_pending_d;

  logic                      handshake_s;
  logic                      sus_fall_s;
  logic                      cur_gate_s;
  logic [KEY_W-1:0]          cur_key_s;
  logic [AGE_W-1:0]          cur_age_s;
  logic [IDX_W-1:0]          tgt_s;

  function automatic logic [CNT_W-1:0] popcount(input logic [VOICES-1:0] v);
    logic [CNT_W-1:0] c;
    c = {CNT_W{1'b0}};
    for (int i = 0; i < VOICES; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  assign ev_ready     = (state_q == ST_IDLE) & ~rel_pending_q & ~all_off & ~rst;
  assign handshake_s  = ev_valid & ev_ready;
  assign sus_fall_s   = sus_q & ~sustain;
  assign voice_key    = key_q;
  assign voice_vel    = vel_q;
  assign voice_gate   = gate_q;
  assign voice_start  = start_q;
  assign active_count = cnt_q;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ev_key_d      = ev_key_q;
    ev_vel_d      = ev_vel_q;
    match_found_d = match_found_q;
    match_idx_d   = match_idx_q;
    free_found_d  = free_found_q;
    free_idx_d    = free_idx_q;
    old_found_d   = old_found_q;
    old_idx_d     = old_idx_q;
    old_age_d     = old_age_q;
    key_d         = key_q;
    vel_d         = vel_q;
    age_d         = age_q;
    gate_d        = gate_q;
    held_d        = held_q;
    start_d       = {VOICES{1'b0}};
    sus_d         = sustain;
    rel_pending_d = rel_pending_q | sus_fall_s;
    cur_gate_s    = gate_q[idx_q];
    cur_key_s     = key_q[idx_q*KEY_W +: KEY_W];
    cur_age_s     = age_q[idx_q*AGE_W +: AGE_W];
    tgt_s         = {IDX_W{1'b0}};

    // Panic clear: key/vel stay, everything that makes a voice sound drops.
    if (all_off) begin
      state_d       = ST_IDLE;
      gate_d        = {VOICES{1'b0}};
      held_d        = {VOICES{1'b0}};
      age_d         = {(VOICES*AGE_W){1'b0}};
      rel_pending_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rel_pending_q) begin
            gate_d        = gate_q & ~held_q;
            held_d        = {VOICES{1'b0}};
            rel_pending_d = sus_fall_s;
          end else if (handshake_s) begin
            ev_key_d      = ev_key;
            ev_vel_d      = ev_vel;
            idx_d         = {IDX_W{1'b0}};
            match_found_d = 1'b0;
            free_found_d  = 1'b0;
            old_found_d   = 1'b0;
            old_age_d     = {AGE_W{1'b0}};
            state_d       = ST_SCAN;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (cur_gate_s && (cur_key_s == ev_key_q) && !match_found_q) begin
            match_found_d = 1'b1;
            match_idx_d   = idx_q;
          end else begin
            match_found_d = match_found_q;
          end
          if (!cur_gate_s && !free_found_q) begin
            free_found_d = 1'b1;
            free_idx_d   = idx_q;
          end else begin
            free_found_d = free_found_q;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (cur_gate_s && (!old_found_q || (cur_age_s > old_age_q))) begin
            old_found_d = 1'b1;
            old_idx_d   = idx_q;
            old_age_d   = cur_age_s;
          end else begin
            old_found_d = old_found_q;
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_COMMIT: begin
          state_d = ST_IDLE;
          if (ev_vel_q != {KEY_W{1'b0}}) begin
            tgt_s = match_found_q ? match_idx_q : (free_found_q ? free_idx_q : old_idx_q);
            for (int i = 0; i < VOICES; i++) begin
              if (IDX_W'(i) == tgt_s) begin
                key_d[i*KEY_W +: KEY_W] = ev_key_q;
                vel_d[i*KEY_W +: KEY_W] = ev_vel_q;
                age_d[i*AGE_W +: AGE_W] = {AGE_W{1'b0}};
                gate_d[i]  = 1'b1;
                held_d[i]  = 1'b0;
                start_d[i] = 1'b1;
              end else if (gate_q[i] && (age_q[i*AGE_W +: AGE_W] != AGE_MAX)) begin
                age_d[i*AGE_W +: AGE_W] = age_q[i*AGE_W +: AGE_W] + 1'b1;
              end else begin
                age_d[i*AGE_W +: AGE_W] = age_q[i*AGE_W +: AGE_W];
              end
            end
          end else if (match_found_q) begin
            if (sus_q) begin
              held_d[match_idx_q] = 1'b1;
            end else begin
              gate_d[match_idx_q] = 1'b0;
              held_d[match_idx_q] = 1'b0;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    cnt_d = popcount(gate_d);
  end

  // State, voice bank and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      idx_q         <= {IDX_W{1'b0}};
      ev_key_q      <= {KEY_W{1'b0}};
      ev_vel_q      <= {KEY_W{1'b0}};
      match_found_q <= 1'b0;
      match_idx_q   <= {IDX_W{1'b0}};
      free_found_q  <= 1'b0;
      free_idx_q    <= {IDX_W{1'b0}};
      old_found_q   <= 1'b0;
      old_idx_q     <= {IDX_W{1'b0}};
      old_age_q     <= {AGE_W{1'b0}};
      key_q         <= {(VOICES*KEY_W){1'b0}};
      vel_q         <= {(VOICES*KEY_W){1'b0}};
      age_q         <= {(VOICES*AGE_W){1'b0}};
      gate_q        <= {VOICES{1'b0}};
      held_q        <= {VOICES{1'b0}};
      start_q       <= {VOICES{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      sus_q         <= 1'b0;
      rel_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ev_key_q      <= ev_key_d;
      ev_vel_q      <= ev_vel_d;
      match_found_q <= match_found_d;
      match_idx_q   <= match_idx_d;
      free_found_q  <= free_found_d;
      free_idx_q    <= free_idx_d;
      old_found_q   <= old_found_d;
      old_idx_q     <= old_idx_d;
      old_age_q     <= old_age_d;
      key_q         <= key_d;
      vel_q         <= vel_d;
      age_q         <= age_d;
      gate_q        <= gate_d;
      held_q        <= held_d;
      start_q       <= start_d;
      cnt_q         <= cnt_d;
      sus_q         <= sus_d;
      rel_pending_q <= rel_pending_d;
    end
  end

endmodule

// File: doc/midi_voice_alloc.md
Name: midi_voice_alloc

Overview:
- Polyphonic voice allocator. It sits between the MIDI note FIFO and a bank of VOICES Karplus-Strong voices, and replaces the single key register / note_off logic of the monophonic synth.
- Accepts note-on/note-off events, assigns note-ons to free voices, and steals the oldest voice when all voices are busy.
- Handles sustain-pedal hold, and drives a per-voice key, velocity, gate and start pulse.

Parameters:
- VOICES, 4, number of voice slots (2..16).
- KEY_W, 8, key and velocity width.
- AGE_W, 4, width of each per-voice age counter; counters saturate at 2^AGE_W-1.
- CNT_W, 3, width of active_count; must hold the value VOICES.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- ev_valid  in  1  event available; in the note FIFO interface this is ~empty.
- ev_key  in  KEY_W  MIDI key number.
- ev_vel  in  KEY_W  velocity; 0 means note-off.
- ev_ready  out  1  allocator accepts an event; handshake = ev_valid & ev_ready, which also serves as the FIFO rd.
- sustain  in  1  sustain pedal level, 1 = pressed.
- all_off  in  1  panic; synchronous clear of all voices.
- voice_key  out  VOICES*KEY_W  packed; voice i occupies bits [i*KEY_W +: KEY_W].
- voice_vel  out  VOICES*KEY_W  packed velocity per voice.
- voice_gate  out  VOICES  1 = voice sounding.
- voice_start  out  VOICES  one-cycle pulse that (re)starts the voice; drives karplus_strong newnote.
- active_count  out  CNT_W  population count of voice_gate.

Behaviour:
- Reset and clock: rst is synchronous, active-high; clock is clk.
- Reset values:
  - voice_key, voice_vel, voice_gate, voice_start, active_count, ages, held flags, rel_pending: all 0.
  - FSM in IDLE.
  - ev_ready is 0 while rst is high.
- ev_ready is combinational: (state==IDLE) & ~rel_pending & ~all_off & ~rst.
- FSM states:
  - IDLE: on the handshake, register key and vel, set idx=0, go to SCAN.
  - SCAN: one voice per cycle, idx 0..VOICES-1, for exactly VOICES cycles, then go to COMMIT. Scan results tracked:
    - match: gate=1 and key equal; lowest index wins.
    - free: gate=0; lowest index wins.
    - oldest: max age among gated voices; ties go to the lowest index.
  - COMMIT: apply the rules below in 1 cycle, then return to IDLE.
- Timing: ev_ready is low for VOICES+1 cycles after the handshake cycle. Outputs update on the COMMIT clock edge. voice_start is high for exactly the one cycle after COMMIT.
- Note-on (vel≠0), target priority: match (retrigger), then free, then oldest (steal). For the target voice:
  - key and vel are loaded, gate=1, held=0, age=0, start pulse issued.
  - Every other gated voice increments its age, saturating.
- Note-off (vel=0), on match:
  - sustain=1: held=1, gate stays 1.
  - sustain=0: gate=0, held=0.
  - No match: no output change; the event is still consumed.
  - Never produces a start pulse.
- Sustain release: the falling edge of registered sustain sets rel_pending. In the first IDLE cycle with rel_pending set, every voice with held=1 is cleared to gate=0, held=0, and rel_pending is cleared. ev_ready is low during that cycle.
- all_off:
  - Takes priority over everything except rst.
  - On the next edge: all gate, held and age cleared, rel_pending=0, FSM to IDLE, any in-flight event discarded with no start pulse.
  - voice_key and voice_vel are retained.
- rst mid-SCAN: full reset; the in-flight event is lost.
- active_count is registered and updates on the same edge as voice_gate.
- A released voice keeps its key and vel values; only gate drops.

Test Plan:
- Keys 60, 64, 67, all vel 100, back-to-back, VOICES=4 -> voice_start pulses on bits 0, 1, 2 in turn. voice_gate=4'b0111, active_count=3, ev_ready low 5 cycles after each handshake.
- Fill the voices with 60, 62, 64, 65, then note-on 67 -> voice 0 is stolen: voice_key[0]=67, voice_start=4'b0001, active_count stays 4.
- With 60, 62, 64 active, note-on 62 vel 30 -> voice 1 retriggers: voice_vel[1]=30, voice_start=4'b0010. Voices 0 and 2 are unchanged except for age.
- sustain=1, note-off 60 -> gate[0] stays 1. Then sustain goes 1->0 while IDLE -> gate[0]=0 two cycles after the falling edge, ev_ready low for that release cycle.
- all_off pulsed in the 2nd SCAN cycle of a note-on -> voice_gate=0, active_count=0, no voice_start pulse, ev_ready=1 on the following cycle.
- Note-off for key 72 with no voice holding it -> no change on any voice output. rst asserted mid-SCAN -> all outputs at reset values next cycle.
